appx_mult_pipe: RTL and testbench
=================================

APPX_MULT_PIPE -- requirements
Module: appx_mult_pipe

Interface
REQ-001 Parameter W, default 8: operand width in bits, legal range 4..16.
REQ-002 Parameter CNT_W, default 16: width of both statistics counters.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  operand beat offered.
REQ-006 in_ready  output  1  operand beat accepted when in_valid and in_ready are both high.
REQ-007 a  input  W  multiplicand, unsigned.
REQ-008 b  input  W  multiplier, unsigned.
REQ-009 mode  input  2  0 exact; 1 leading-one; 2 top-two-bits; 3 reserved, treated as exact.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  result beat consumed when out_valid and out_ready are both high.
REQ-012 y  output  2W  product, unsigned, never truncated.
REQ-013 y_mode  output  2  mode value that produced y.
REQ-014 clr_stats  input  1  synchronous clear of both counters.
REQ-015 op_cnt  output  CNT_W  count of results consumed.
REQ-016 err_cnt  output  CNT_W  count of consumed results that differ from the exact product.

Function
REQ-017 Effective multiplier b' per mode. Mode 0 and mode 3: b' = b. Mode 1: b' keeps only the leading one bit of b. Mode 2: b' keeps the leading one bit and the next lower bit of b, with all other bits zero. For b = 0, b' = 0 in every mode.
REQ-018 y = a * b', computed at full 2W width.
REQ-019 Two-stage pipeline. Stage 1 registers a, b', mode and the exact product. Stage 2 registers y, y_mode and a mismatch flag (y != a*b).
REQ-020 Latency is exactly 2 cycles from acceptance to out_valid when out_ready is held high; throughput is 1 beat per cycle.
REQ-021 Each stage advances when it is empty or when its downstream consumer takes its contents in the same cycle.
REQ-022 in_ready = stage-1 empty OR stage 1 advancing; in_ready is combinational from out_ready.
REQ-023 While out_valid=1 and out_ready=0, y and y_mode are held stable; no beat is dropped or duplicated.
REQ-024 Under backpressure the pipeline holds at most 2 beats; in_ready deasserts in the cycle stage 1 is full and cannot advance.
REQ-025 op_cnt increments on each consumed result. err_cnt increments on each consumed result whose mismatch flag is set.
REQ-026 Both counters saturate at 2^CNT_W-1 and do not wrap.
REQ-027 clr_stats has priority over increment; the counters read 0 on the next cycle, and a consume in the clear cycle is not counted.
REQ-028 Mode is sampled per beat; mixed modes in flight are allowed and results retain their own y_mode.

Reset
REQ-029 While rst_n=0 at a clock edge, the block SHALL set: both stages empty, out_valid=0, y=0, y_mode=0, op_cnt=0, err_cnt=0.
REQ-030 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release.
REQ-031 Reset mid-operation SHALL discard all in-flight beats, with no partial result emitted afterwards.

Structure
REQ-032 Package appx_mult_pkg SHALL hold the mode enumeration (MODE_EXACT, MODE_LEAD1, MODE_LEAD2, MODE_RSVD) and the legal-W bounds.
REQ-033 The b-to-b' truncation SHALL be a combinational sub-module appx_b_trunc (parameter W; inputs b and mode; output b'), instantiated in stage 1.
REQ-034 Pipeline control, product registers and counters SHALL live in appx_mult_pipe; target is 150-300 lines.

Verification (W=8)
REQ-035 a=10, b=7, issued back-to-back in modes 0, 1 and 2 -> y = 70, 40 and 60 on 3 consecutive cycles, first result 2 cycles after acceptance; err_cnt=2, op_cnt=3.
REQ-036 a=255, b=255, mode 0 -> y=65025; mode 2 on the same operands -> y=255*192=48960.
REQ-037 b=0 and b=1 in every mode -> y=0 and y=a respectively; err_cnt unchanged.
REQ-038 out_ready=0 for 6 cycles with in_valid=1 continuously -> exactly 2 beats accepted, then in_ready=0 and y stable; on release the results drain in order with no loss.
REQ-039 rst_n=0 for 1 cycle with 2 beats in flight -> out_valid=0 next cycle, counters=0, no stale beat afterwards.
REQ-040 CNT_W=4, with 20 mismatching beats consumed -> err_cnt=op_cnt=15 (saturated); clr_stats pulsed together with a consume -> both read 0.

Source files
------------

// File: rtl/appx_mult_pkg.sv
// Shared types and constants for the approximate multiplier pipeline.
package appx_mult_pkg;
  localparam int W_MIN  = 4;
  localparam int W_MAX  = 16;
  localparam int STAGES = 2;

  typedef enum logic [1:0] {
    MODE_EXACT = 2'd0,
    MODE_LEAD1 = 2'd1,
    MODE_LEAD2 = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;
endpackage

// File: rtl/appx_b_trunc.sv
// Combinational multiplier truncation: keeps the leading one (mode 1) or the
// leading one plus the next lower bit (mode 2); other modes pass b through.
module appx_b_trunc
  import appx_mult_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] b,
  input  mode_e        mode,
  output logic [W-1:0] b_trunc
);
  logic [W-1:0] lead;

  // Ascending scan; the last set bit seen is the most significant one.
  always_comb begin
    lead = '0;
    for (int i = 0; i < W; i++)
      if (b[i]) lead = W'(1) << i;
  end

  always_comb begin
    case (mode)
      MODE_LEAD1: b_trunc = lead;
      MODE_LEAD2: b_trunc = b & (lead | (lead >> 1));
      default:    b_trunc = b;
    endcase
  end
endmodule

// File: rtl/appx_mult_pipe.sv
// Two-stage valid/ready approximate multiplier with consume and error
// statistics counters.
module appx_mult_pipe
  import appx_mult_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   y,
  output logic [1:0]       y_mode,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] op_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [W-1:0]   a;
    logic [W-1:0]   bp;
    mode_e          mode;
    logic [2*W-1:0] exact;
  } s1_t;

  typedef struct packed {
    logic [2*W-1:0] y;
    mode_e          mode;
    logic           mis;
  } s2_t;

  logic [STAGES:1] vld_pipe;
  s1_t             s1_q, s1_d;
  s2_t             s2_q, s2_d;
  logic [W-1:0]    bp;
  mode_e           mode_in;
  logic            adv1, adv2, fire_in, fire_out;

  assign mode_in = mode_e'(mode);

  appx_b_trunc #(.W(W)) u_trunc (
    .b       (b),
    .mode    (mode_in),
    .b_trunc (bp)
  );

  assign adv2     = !vld_pipe[2] || out_ready;
  assign adv1     = !vld_pipe[1] || adv2;
  assign in_ready = rst_n && adv1;
  assign fire_in  = in_valid && in_ready;
  assign fire_out = vld_pipe[2] && out_ready;

  always_comb begin
    s1_d       = '0;
    s1_d.a     = a;
    s1_d.bp    = bp;
    s1_d.mode  = mode_in;
    s1_d.exact = (2*W)'(a) * (2*W)'(b);
  end

  always_comb begin
    s2_d      = '0;
    s2_d.y    = (2*W)'(s1_q.a) * (2*W)'(s1_q.bp);
    s2_d.mode = s1_q.mode;
    s2_d.mis  = (s2_d.y != s1_q.exact);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (adv1) begin
        vld_pipe[1] <= fire_in;
        if (fire_in) s1_q <= s1_d;
      end
      if (adv2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= s2_d;
      end
    end
  end

  assign out_valid = vld_pipe[2];
  assign y         = s2_q.y;
  assign y_mode    = s2_q.mode;

  // Clear wins over a same-cycle consume; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_stats) begin
      op_cnt  <= '0;
      err_cnt <= '0;
    end else if (fire_out) begin
      if (op_cnt != CNT_MAX) op_cnt <= op_cnt + 1'b1;
      if (s2_q.mis && err_cnt != CNT_MAX) err_cnt <= err_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_appx_mult_pipe.sv
// Directed-vector bench for appx_mult_pipe (W=8, CNT_W=4 so saturation is reachable).
module tb_appx_mult_pipe;
  localparam int W     = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   y;
  logic [1:0]       y_mode;
  logic             clr_stats;
  logic [CNT_W-1:0] op_cnt;
  logic [CNT_W-1:0] err_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  appx_mult_pipe #(.W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .y_mode    (y_mode),
    .clr_stats (clr_stats),
    .op_cnt    (op_cnt),
    .err_cnt   (err_cnt)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Offers one beat into an idle pipeline and returns the consumed result.
  task automatic send_one(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [1:0] im,
                          output logic [2*W-1:0] oy, output logic [1:0] om, output bit ok);
    bit acc;
    ok = 0; oy = '0; om = '0; acc = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; a = ia; b = ib; mode = im;
    for (int i = 0; i < 10 && !acc; i++) begin
      acc = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (acc) begin
      for (int i = 0; i < 10 && !ok; i++) begin
        if (out_valid) begin
          oy = y; om = y_mode; ok = 1;
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic clear_stats();
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_stats = 1'b0;
    a = '0; b = '0; mode = '0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (y !== 16'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", y); end
    checks++; if (y_mode !== 2'd0) begin failures++; $display("FAIL reset_y_mode got=%0d exp=0", y_mode); end
    checks++; if (op_cnt !== 4'd0) begin failures++; $display("FAIL reset_op_cnt got=%0d exp=0", op_cnt); end
    checks++; if (err_cnt !== 4'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
  endtask

  // a=10,b=7 in modes 0,1,2 back-to-back: 70, 40, 60 two cycles after acceptance.
  task automatic test_modes();
    logic [15:0] ey [3];
    ey[0] = 16'd70; ey[1] = 16'd40; ey[2] = 16'd60;
    out_ready = 1'b1;
    clear_stats();
    for (int c = 0; c < 6; c++) begin
      if (c >= 2 && c < 5) begin
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL modes_valid c=%0d got=%0b exp=1", c, out_valid); end
        checks++; if (y !== ey[c-2]) begin failures++; $display("FAIL modes_y c=%0d got=%0d exp=%0d", c, y, ey[c-2]); end
        checks++; if (y_mode !== 2'(c-2)) begin failures++; $display("FAIL modes_y_mode c=%0d got=%0d exp=%0d", c, y_mode, c-2); end
      end else begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL modes_idle c=%0d got=%0b exp=0", c, out_valid); end
      end
      if (c < 3) begin
        in_valid = 1'b1; a = 8'd10; b = 8'd7; mode = 2'(c);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    checks++; if (op_cnt !== 4'd3) begin failures++; $display("FAIL modes_op_cnt got=%0d exp=3", op_cnt); end
    checks++; if (err_cnt !== 4'd2) begin failures++; $display("FAIL modes_err_cnt got=%0d exp=2", err_cnt); end
  endtask

  task automatic test_boundary();
    logic [15:0] ry;
    logic [1:0]  rm;
    bit          ok;
    clear_stats();
    send_one(8'd255, 8'd255, 2'd0, ry, rm, ok);
    checks++; if (!ok || ry !== 16'd65025) begin failures++; $display("FAIL max_exact ok=%0b got=%0d exp=65025", ok, ry); end
    send_one(8'd255, 8'd255, 2'd2, ry, rm, ok);
    checks++; if (!ok || ry !== 16'd48960) begin failures++; $display("FAIL max_lead2 ok=%0b got=%0d exp=48960", ok, ry); end
    checks++; if (rm !== 2'd2) begin failures++; $display("FAIL max_lead2_mode got=%0d exp=2", rm); end
    for (int m = 0; m < 4; m++) begin
      send_one(8'd173, 8'd0, 2'(m), ry, rm, ok);
      checks++; if (!ok || ry !== 16'd0) begin failures++; $display("FAIL b0 mode=%0d ok=%0b got=%0d exp=0", m, ok, ry); end
      send_one(8'd173, 8'd1, 2'(m), ry, rm, ok);
      checks++; if (!ok || ry !== 16'd173) begin failures++; $display("FAIL b1 mode=%0d ok=%0b got=%0d exp=173", m, ok, ry); end
      checks++; if (rm !== 2'(m)) begin failures++; $display("FAIL b1_mode got=%0d exp=%0d", rm, m); end
    end
    send_one(8'd10, 8'd7, 2'd3, ry, rm, ok);
    checks++; if (!ok || ry !== 16'd70) begin failures++; $display("FAIL rsvd_exact ok=%0b got=%0d exp=70", ok, ry); end
    checks++; if (op_cnt !== 4'd11) begin failures++; $display("FAIL bound_op_cnt got=%0d exp=11", op_cnt); end
    checks++; if (err_cnt !== 4'd1) begin failures++; $display("FAIL bound_err_cnt got=%0d exp=1", err_cnt); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    clr_stats = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    clr_stats = 1'b0;
    for (int c = 0; c < 6; c++) begin
      checks++; if (in_ready !== (c < 2)) begin failures++; $display("FAIL bp_in_ready c=%0d got=%0b exp=%0b", c, in_ready, c < 2); end
      if (c >= 2) begin
        checks++; if (out_valid !== 1'b1 || y !== 16'd3) begin failures++; $display("FAIL bp_hold c=%0d valid=%0b got=%0d exp=3", c, out_valid, y); end
      end
      in_valid = 1'b1; a = 8'(acc + 1); b = 8'd3; mode = 2'd0;
      if (in_ready) acc++;
      @(negedge clk);
    end
    checks++; if (acc !== 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", acc); end
    checks++; if (y !== 16'd3) begin failures++; $display("FAIL bp_stable got=%0d exp=3", y); end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || y !== 16'd6) begin failures++; $display("FAIL bp_drain2 valid=%0b got=%0d exp=6", out_valid, y); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%0b exp=0", out_valid); end
    checks++; if (op_cnt !== 4'd2) begin failures++; $display("FAIL bp_op_cnt got=%0d exp=2", op_cnt); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'd5; b = 8'd5; mode = 2'd0;
    @(negedge clk);
    a = 8'd6;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_inflight got=%0b exp=1", out_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_out_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_in_ready got=%0b exp=0", in_ready); end
    checks++; if (op_cnt !== 4'd0 || err_cnt !== 4'd0) begin failures++; $display("FAIL mid_cnt got=%0d/%0d exp=0/0", op_cnt, err_cnt); end
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale c=%0d got=%0b exp=0", c, out_valid); end
    end
  endtask

  task automatic test_saturation();
    int acc = 0;
    out_ready = 1'b1;
    clear_stats();
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; a = 8'd10; b = 8'd7; mode = 2'd1;
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (acc !== 20) begin failures++; $display("FAIL sat_accepted got=%0d exp=20", acc); end
    checks++; if (op_cnt !== 4'd15) begin failures++; $display("FAIL sat_op_cnt got=%0d exp=15", op_cnt); end
    checks++; if (err_cnt !== 4'd15) begin failures++; $display("FAIL sat_err_cnt got=%0d exp=15", err_cnt); end
    in_valid = 1'b1; a = 8'd10; b = 8'd7; mode = 2'd1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL clr_setup got=%0b exp=1", out_valid); end
    clr_stats = 1'b1;
    @(negedge clk);
    clr_stats = 1'b0;
    checks++; if (op_cnt !== 4'd0 || err_cnt !== 4'd0) begin failures++; $display("FAIL clr_cnt got=%0d/%0d exp=0/0", op_cnt, err_cnt); end
    @(negedge clk);
    checks++; if (op_cnt !== 4'd0 || err_cnt !== 4'd0) begin failures++; $display("FAIL clr_hold got=%0d/%0d exp=0/0", op_cnt, err_cnt); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
